debug_controller: RTL and testbench

DEBUG_CONTROLLER -- requirements
Module: debug_controller

---
 rtl/debug_ctrl_pkg.sv | 35 +++
 rtl/debug_bp_compare.sv | 52 +++++
 rtl/debug_controller.sv | 140 ++++++++++++++
 tb/tb_debug_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_ctrl_pkg.sv
// Shared definitions for the debug controller: state encoding, register map, CTRL/STATUS bits.
// Breakpoint support is built only when DEBUG_CONTROLLER_BREAKPOINT_EN is defined.
package debug_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } dbg_state_t;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_BP     = 3'd1;
  localparam logic [2:0] ADDR_INSTR  = 3'd2;
  localparam logic [2:0] ADDR_PC     = 3'd3;
  localparam logic [2:0] ADDR_RETIRE = 3'd4;

  localparam int CTRL_HALT    = 0;
  localparam int CTRL_RESUME  = 1;
  localparam int CTRL_STEP    = 2;
  localparam int CTRL_CLR_BP  = 3;
  localparam int CTRL_CLR_CNT = 4;

  localparam int STAT_BP_HIT = 2;
  localparam int STAT_BP_EN  = 3;

  function automatic logic [15:0] status_word(dbg_state_t st, logic hit, logic en);
    logic [15:0] w;
    w              = 16'd0;
    w[1:0]         = st;
    w[STAT_BP_HIT] = hit;
    w[STAT_BP_EN]  = en;
    return w;
  endfunction

endpackage

// File: rtl/debug_bp_compare.sv
// Breakpoint address/enable registers, resume-skip flag and PC match detection.
// Instantiated by debug_controller only when DEBUG_CONTROLLER_BREAKPOINT_EN is defined.
module debug_bp_compare #(
  parameter int PC_WIDTH = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                bp_write,
  input  logic                bp_wr_enable,
  input  logic [PC_WIDTH-1:0] bp_wr_pc,
  input  logic                in_run,
  input  logic                resume,
  input  logic                instr_retire,
  input  logic [PC_WIDTH-1:0] current_pc,
  output logic                bp_enable,
  output logic [15:0]         bp_readback,
  output logic                bp_match
);

  logic [PC_WIDTH-1:0] bp_pc;
  logic                bp_skip;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bp_pc     <= '0;
      bp_enable <= 1'b0;
    end else if (bp_write) begin
      bp_pc     <= bp_wr_pc;
      bp_enable <= bp_wr_enable;
    end
  end

  // Resuming sets skip so the first retire (possibly at the breakpoint PC) cannot re-trigger.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bp_skip <= 1'b0;
    end else if (resume) begin
      bp_skip <= 1'b1;
    end else if (instr_retire) begin
      bp_skip <= 1'b0;
    end
  end

  assign bp_match = in_run & bp_enable & instr_retire & (current_pc == bp_pc) & ~bp_skip;

  always_comb begin
    bp_readback               = 16'd0;
    bp_readback[PC_WIDTH-1:0] = bp_pc;
    bp_readback[15]           = bp_enable;
  end

endmodule

// File: rtl/debug_controller.sv
// Run/halt/step debug controller with an Avalon-MM register slave and retire counter.
// Optional breakpoint logic is enabled by defining DEBUG_CONTROLLER_BREAKPOINT_EN.
module debug_controller
  import debug_ctrl_pkg::*;
#(
  parameter int PC_WIDTH     = 10,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          avl_address,
  input  logic                avl_write,
  input  logic [15:0]         avl_writedata,
  output logic [15:0]         avl_readdata,
  input  logic [15:0]         current_instr,
  input  logic [PC_WIDTH-1:0] current_pc,
  input  logic                instr_retire,
  output logic                cpu_stall
);

  localparam dbg_state_t RST_STATE = RESET_HALTED ? ST_HALT : ST_RUN;

  dbg_state_t  state;
  dbg_state_t  state_next;
  logic [15:0] retire_cnt;
  logic        ctrl_wr;
  logic        do_halt;
  logic        do_resume;
  logic        do_step;
  logic        do_clr_cnt;
  logic        bp_match;
  logic        bp_hit;
  logic        bp_enable;
  logic [15:0] bp_readback;
  logic        unused_wdata;

  assign ctrl_wr      = avl_write && (avl_address == ADDR_CTRL);
  assign do_halt      = ctrl_wr & avl_writedata[CTRL_HALT];
  assign do_resume    = ctrl_wr & avl_writedata[CTRL_RESUME];
  assign do_step      = ctrl_wr & avl_writedata[CTRL_STEP];
  assign do_clr_cnt   = ctrl_wr & avl_writedata[CTRL_CLR_CNT];
  assign unused_wdata = ^avl_writedata;

`ifdef DEBUG_CONTROLLER_BREAKPOINT_EN
  logic resume_to_run;

  assign resume_to_run = (state == ST_HALT) && (state_next == ST_RUN);

  debug_bp_compare #(
    .PC_WIDTH(PC_WIDTH)
  ) u_bp (
    .clk          (clk),
    .reset_n      (reset_n),
    .bp_write     (avl_write && (avl_address == ADDR_BP)),
    .bp_wr_enable (avl_writedata[15]),
    .bp_wr_pc     (avl_writedata[PC_WIDTH-1:0]),
    .in_run       (state == ST_RUN),
    .resume       (resume_to_run),
    .instr_retire (instr_retire),
    .current_pc   (current_pc),
    .bp_enable    (bp_enable),
    .bp_readback  (bp_readback),
    .bp_match     (bp_match)
  );

  // A new match wins over a same-cycle clear so no hit is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bp_hit <= 1'b0;
    end else if (bp_match) begin
      bp_hit <= 1'b1;
    end else if (ctrl_wr && avl_writedata[CTRL_CLR_BP]) begin
      bp_hit <= 1'b0;
    end
  end
`else
  assign bp_match    = 1'b0;
  assign bp_hit      = 1'b0;
  assign bp_enable   = 1'b0;
  assign bp_readback = 16'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RST_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (do_halt || bp_match) state_next = ST_HALT;
        else                     state_next = ST_RUN;
      end
      ST_HALT: begin
        if (do_halt)        state_next = ST_HALT;
        else if (do_resume) state_next = ST_RUN;
        else if (do_step)   state_next = ST_STEP;
        else                state_next = ST_HALT;
      end
      ST_STEP: begin
        if (do_halt || instr_retire) state_next = ST_HALT;
        else                         state_next = ST_STEP;
      end
      default: state_next = RST_STATE;
    endcase
  end

  // Retires are counted in every state; a clear overrides a same-cycle retire.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retire_cnt <= 16'd0;
    end else if (do_clr_cnt) begin
      retire_cnt <= 16'd0;
    end else if (instr_retire) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avl_readdata <= 16'd0;
    end else begin
      case (avl_address)
        ADDR_CTRL:   avl_readdata <= status_word(state, bp_hit, bp_enable);
        ADDR_BP:     avl_readdata <= bp_readback;
        ADDR_INSTR:  avl_readdata <= current_instr;
        ADDR_PC:     avl_readdata <= 16'(current_pc);
        ADDR_RETIRE: avl_readdata <= retire_cnt;
        default:     avl_readdata <= 16'd0;
      endcase
    end
  end

  assign cpu_stall = (state == ST_HALT);

endmodule

// File: tb/tb_debug_controller.sv
// Self-checking bench for debug_controller (RESET_HALTED=1) against a behavioural model.
// Breakpoint scenarios follow DEBUG_CONTROLLER_BREAKPOINT_EN.
module tb_debug_controller;

  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    avl_address = 3'd0;
  logic          avl_write = 1'b0;
  logic [15:0]   avl_writedata = 16'd0;
  logic [15:0]   avl_readdata;
  logic [15:0]   current_instr = 16'd0;
  logic [PW-1:0] current_pc = '0;
  logic          instr_retire = 1'b0;
  logic          cpu_stall;

  int n_tests = 0;
  int n_fail  = 0;

  // model: state 0=RUN 1=HALT 2=STEP
  int          m_state;
  bit          m_hit, m_skip, m_en;
  int          m_bppc;
  int          m_cnt;
  logic [15:0] exp_rd;
  logic        exp_stall;

  debug_controller #(.PC_WIDTH(PW), .RESET_HALTED(1'b1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avl_address   (avl_address),
    .avl_write     (avl_write),
    .avl_writedata (avl_writedata),
    .avl_readdata  (avl_readdata),
    .current_instr (current_instr),
    .current_pc    (current_pc),
    .instr_retire  (instr_retire),
    .cpu_stall     (cpu_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_read(int addr);
    case (addr)
      0: return 16'(m_state + (m_hit ? 4 : 0) + (m_en ? 8 : 0));
      1: return 16'((m_en ? 32768 : 0) + m_bppc);
      2: return current_instr;
      3: return 16'(current_pc);
      4: return 16'(m_cnt);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic cycle(input int addr, input bit wr, input logic [15:0] wd, input bit ret, input int pc);
    bit ctrl, h, r, s, cb, cc, match;
    int nxt;
    @(negedge clk);
    reset_n       = 1'b1;
    avl_address   = 3'(addr);
    avl_write     = wr;
    avl_writedata = wd;
    instr_retire  = ret;
    current_pc    = PW'(pc);
    current_instr = 16'($urandom);
    exp_rd = model_read(addr);
    ctrl  = wr && (addr == 0);
    h     = ctrl && wd[0];
    r     = ctrl && wd[1];
    s     = ctrl && wd[2];
    cb    = ctrl && wd[3];
    cc    = ctrl && wd[4];
    match = 1'b0;
`ifdef DEBUG_CONTROLLER_BREAKPOINT_EN
    match = (m_state == 0) && m_en && ret && (pc == m_bppc) && !m_skip;
`endif
    nxt = m_state;
    if (m_state == 0) begin
      if (h || match) nxt = 1;
    end else if (m_state == 1) begin
      if (h) nxt = 1;
      else if (r) nxt = 0;
      else if (s) nxt = 2;
    end else begin
      if (h || ret) nxt = 1;
    end
`ifdef DEBUG_CONTROLLER_BREAKPOINT_EN
    if (m_state == 1 && nxt == 0) m_skip = 1'b1;
    else if (ret) m_skip = 1'b0;
    if (match) m_hit = 1'b1;
    else if (cb) m_hit = 1'b0;
    if (wr && addr == 1) begin
      m_en   = wd[15];
      m_bppc = int'(wd[PW-1:0]);
    end
`endif
    if (cc) m_cnt = 0;
    else if (ret) m_cnt = (m_cnt + 1) % 65536;
    m_state   = nxt;
    exp_stall = (nxt == 1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input bit wr, input logic [15:0] wd, input bit ret);
    @(negedge clk);
    reset_n       = 1'b0;
    avl_address   = 3'd0;
    avl_write     = wr;
    avl_writedata = wd;
    instr_retire  = ret;
    m_state = 1; m_hit = 0; m_skip = 0; m_en = 0; m_bppc = 0; m_cnt = 0;
    exp_rd = 16'h0000;
    exp_stall = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_cycle(1'b1, 16'h0002, 1'b1);
    n_tests++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall: got %b want 1", cpu_stall);
    end
    n_tests++;
    if (avl_readdata !== 16'h0000) begin
      n_fail++; $display("FAIL reset_readdata: got %h want 0000", avl_readdata);
    end
    cycle(0, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0001) begin
      n_fail++; $display("FAIL reset_status: got %h want 0001", avl_readdata);
    end
    cycle(4, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0000) begin
      n_fail++; $display("FAIL reset_count: got %h want 0000", avl_readdata);
    end
  endtask

  task automatic test_resume();
    reset_cycle(1'b0, 16'h0, 1'b0);
    cycle(0, 1, 16'h0002, 0, 0);
    n_tests++;
    if (cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL resume_stall: got %b want 0", cpu_stall);
    end
    cycle(0, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0000) begin
      n_fail++; $display("FAIL resume_status: got %h want 0000", avl_readdata);
    end
  endtask

  task automatic test_step();
    reset_cycle(1'b0, 16'h0, 1'b0);
    cycle(0, 1, 16'h0004, 0, 0);
    n_tests++;
    if (cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL step_enter: got %b want 0", cpu_stall);
    end
    cycle(0, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0002) begin
      n_fail++; $display("FAIL step_status: got %h want 0002", avl_readdata);
    end
    cycle(0, 0, 16'h0, 1, 3);
    n_tests++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL step_retire1: got %b want 1", cpu_stall);
    end
    cycle(0, 0, 16'h0, 1, 4);
    n_tests++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL step_retire2: got %b want 1", cpu_stall);
    end
    cycle(4, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0002) begin
      n_fail++; $display("FAIL step_count: got %h want 0002", avl_readdata);
    end
  endtask

  task automatic test_priority();
    reset_cycle(1'b0, 16'h0, 1'b0);
    cycle(0, 1, 16'h0003, 0, 0);
    n_tests++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL prio_halt_resume: got %b want 1", cpu_stall);
    end
    cycle(0, 1, 16'h0006, 0, 0);
    n_tests++;
    if (cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL prio_resume_step: got %b want 0", cpu_stall);
    end
    cycle(0, 0, 16'h0, 1, 9);
    n_tests++;
    if (cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL prio_run_retire: got %b want 0", cpu_stall);
    end
  endtask

  task automatic test_breakpoint();
    reset_cycle(1'b0, 16'h0, 1'b0);
    cycle(1, 1, 16'h8012, 0, 0);
    cycle(1, 0, 16'h0, 0, 0);
    n_tests++;
`ifdef DEBUG_CONTROLLER_BREAKPOINT_EN
    if (avl_readdata !== 16'h8012) begin
      n_fail++; $display("FAIL bp_readback: got %h want 8012", avl_readdata);
    end
    cycle(0, 1, 16'h0002, 0, 0);
    cycle(0, 0, 16'h0, 1, 5);
    cycle(0, 0, 16'h0, 1, 16'h012);
    n_tests++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL bp_halt: got %b want 1", cpu_stall);
    end
    cycle(0, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h000D) begin
      n_fail++; $display("FAIL bp_status: got %h want 000d", avl_readdata);
    end
    cycle(0, 1, 16'h0002, 0, 0);
    cycle(0, 0, 16'h0, 1, 16'h012);
    n_tests++;
    if (cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL bp_skip: got %b want 0", cpu_stall);
    end
    cycle(0, 0, 16'h0, 1, 16'h012);
    n_tests++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL bp_rehit: got %b want 1", cpu_stall);
    end
    cycle(0, 1, 16'h0008, 0, 0);
    cycle(0, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0009) begin
      n_fail++; $display("FAIL bp_clear: got %h want 0009", avl_readdata);
    end
`else
    if (avl_readdata !== 16'h0000) begin
      n_fail++; $display("FAIL nobp_readback: got %h want 0000", avl_readdata);
    end
    cycle(0, 1, 16'h0002, 0, 0);
    cycle(0, 0, 16'h0, 1, 16'h012);
    cycle(0, 0, 16'h0, 1, 16'h012);
    n_tests++;
    if (cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL nobp_no_halt: got %b want 0", cpu_stall);
    end
    cycle(0, 1, 16'h0008, 0, 0);
    cycle(0, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0000) begin
      n_fail++; $display("FAIL nobp_status: got %h want 0000", avl_readdata);
    end
`endif
  endtask

  task automatic test_counter_wrap();
    reset_cycle(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 65535; i++) cycle(2, 0, 16'h0, 1, i % 512);
    cycle(4, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'hFFFF) begin
      n_fail++; $display("FAIL cnt_preload: got %h want ffff", avl_readdata);
    end
    cycle(4, 0, 16'h0, 1, 0);
    cycle(4, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0000) begin
      n_fail++; $display("FAIL cnt_wrap: got %h want 0000", avl_readdata);
    end
    for (int i = 0; i < 3; i++) cycle(4, 0, 16'h0, 1, 0);
    cycle(0, 1, 16'h0010, 1, 0);
    cycle(4, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0000) begin
      n_fail++; $display("FAIL cnt_clear_retire: got %h want 0000", avl_readdata);
    end
  endtask

  task automatic test_reset_mid_step();
    reset_cycle(1'b0, 16'h0, 1'b0);
    cycle(0, 1, 16'h0004, 0, 0);
    reset_cycle(1'b1, 16'h0002, 1'b1);
    n_tests++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL rst_step_stall: got %b want 1", cpu_stall);
    end
    cycle(0, 0, 16'h0, 0, 0);
    n_tests++;
    if (avl_readdata !== 16'h0001) begin
      n_fail++; $display("FAIL rst_step_status: got %h want 0001", avl_readdata);
    end
  endtask

  task automatic test_random();
    int          addr;
    bit          wr;
    logic [15:0] wd;
    reset_cycle(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      addr = $urandom_range(0, 7);
      wr   = ($urandom_range(0, 4) == 0);
      if (addr == 1) wd = 16'(($urandom_range(0, 1) << 15) | $urandom_range(0, 7));
      else           wd = 16'($urandom & $urandom);
      cycle(addr, wr, wd, ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
      n_tests++;
      if (avl_readdata !== exp_rd || cpu_stall !== exp_stall) begin
        n_fail++;
        $display("FAIL random[%0d]: addr %0d rd %h stall %b want rd %h stall %b",
                 i, addr, avl_readdata, cpu_stall, exp_rd, exp_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_resume();
    test_step();
    test_priority();
    test_breakpoint();
    test_counter_wrap();
    test_reset_mid_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
